// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// State encoding, header tag and header-byte builder.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_HDR_START = 3'd2,
    ST_HDR_WAIT  = 3'd3,
    ST_DAT_START = 3'd4,
    ST_DAT_WAIT  = 3'd5
  } state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;

  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr+1,
// wrapping modulo NREQ.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_valid
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = ID_W'((32'(i_ptr) + k) % NREQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte requesters, round-robin,
// with an optional {A, id} header byte ahead of each payload byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ID_W      = 2,
  parameter int HDR_EN    = 1,
  parameter int START_TMO = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic              uart_tx_start,
  output logic [7:0]        uart_data,
  input  logic              uart_tx_busy,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id,
  output logic              tmo_err
);

  localparam int CNT_W = $clog2(START_TMO + 1);

  state_t            r_state, w_next;
  logic [ID_W-1:0]   r_ptr, r_grant_id;
  logic [7:0]        r_byte, r_uart_data;
  logic [NREQ-1:0]   r_ack;
  logic              r_tx_start, r_seen_busy, r_tmo;
  logic [CNT_W-1:0]  r_cnt;
  logic [NREQ-1:0]   w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_valid, w_tmo_hit, w_frame_done;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Phase A (before busy rises) may end by timeout; phase B ends on busy fall.
  assign w_tmo_hit    = !r_seen_busy && !uart_tx_busy && (r_cnt == CNT_W'(START_TMO - 1));
  assign w_frame_done = (r_seen_busy && !uart_tx_busy) || w_tmo_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_valid) w_next = ST_GRANT;
      ST_GRANT:     if (!uart_tx_busy) w_next = (HDR_EN != 0) ? ST_HDR_START : ST_DAT_START;
      ST_HDR_START: w_next = ST_HDR_WAIT;
      ST_HDR_WAIT:  if (w_frame_done) w_next = ST_DAT_START;
      ST_DAT_START: w_next = ST_DAT_WAIT;
      ST_DAT_WAIT:  if (w_frame_done) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack       <= '0;
      r_tx_start  <= 1'b0;
      r_uart_data <= '0;
      r_grant_id  <= '0;
      r_ptr       <= '0;
      r_byte      <= '0;
      r_tmo       <= 1'b0;
      r_cnt       <= '0;
      r_seen_busy <= 1'b0;
    end else begin
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_ack      <= w_grant;
            r_grant_id <= w_idx;
            r_ptr      <= w_idx;
            r_byte     <= req_data[8*w_idx +: 8];
          end
        end
        ST_HDR_START, ST_DAT_START: begin
          r_uart_data <= (r_state == ST_HDR_START) ? hdr_byte(4'(r_grant_id)) : r_byte;
          r_tx_start  <= 1'b1;
          r_cnt       <= '0;
          r_seen_busy <= 1'b0;
        end
        ST_HDR_WAIT, ST_DAT_WAIT: begin
          if (!r_seen_busy) begin
            if (uart_tx_busy)   r_seen_busy <= 1'b1;
            else if (w_tmo_hit) r_tmo       <= 1'b1;
            else                r_cnt       <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ack       = r_ack;
  assign uart_tx_start = r_tx_start;
  assign uart_data     = r_uart_data;
  assign busy          = (r_state != ST_IDLE);
  assign grant_id      = r_grant_id;
  assign tmo_err       = r_tmo;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: randomized requests against a
// round-robin/frame-list reference model, plus timeout and reset scenarios.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  // DUT A: header enabled
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ack;
  logic        uart_tx_start;
  logic [7:0]  uart_data;
  logic        m_busy = 1'b0, ext_busy = 1'b0;
  logic        uart_tx_busy;
  logic        busy;
  logic [1:0]  grant_id;
  logic        tmo_err;
  assign uart_tx_busy = m_busy | ext_busy;

  uart_tx_arbiter #(.NREQ(4), .ID_W(2), .HDR_EN(1), .START_TMO(255)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_ack(req_ack),
    .uart_tx_start(uart_tx_start), .uart_data(uart_data), .uart_tx_busy(uart_tx_busy),
    .busy(busy), .grant_id(grant_id), .tmo_err(tmo_err)
  );

  // DUT B: header disabled
  logic [3:0]  b_req = '0;
  logic [31:0] b_data = '0;
  logic [3:0]  b_ack;
  logic        b_start;
  logic [7:0]  b_udata;
  logic        b_ubusy = 1'b0;
  logic        b_busy;
  logic [1:0]  b_gid;
  logic        b_tmo;

  uart_tx_arbiter #(.NREQ(4), .ID_W(2), .HDR_EN(0), .START_TMO(255)) dut_nohdr (
    .clk(clk), .reset(reset), .req(b_req), .req_data(b_data), .req_ack(b_ack),
    .uart_tx_start(b_start), .uart_data(b_udata), .uart_tx_busy(b_ubusy),
    .busy(b_busy), .grant_id(b_gid), .tmo_err(b_tmo)
  );

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  bit uart_en = 1'b1;
  logic [7:0] frames[$];
  logic [7:0] b_frames[$];
  logic [7:0] exp_q[$];
  int mptr = 0;

  // UART behaviour: capture byte on start, raise busy a cycle later for a random time
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx_start === 1'b1 && uart_en) begin
        frames.push_back(uart_data);
        @(posedge clk); #1 m_busy = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1 m_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (b_start === 1'b1) begin
        b_frames.push_back(b_udata);
        @(posedge clk); #1 b_ubusy = 1'b1;
        repeat (3) @(posedge clk);
        #1 b_ubusy = 1'b0;
      end
    end
  end

  // Continuous ack one-hot monitor
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx_start === 1'b1) start_cnt++;
      if (req_ack !== 4'b0000) begin
        checks++;
        if ($countones(req_ack) != 1) begin
          failures++;
          $display("FAIL ack_onehot got=%b required=one bit set", req_ack);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_grant(input int p, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic int q_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic wait_ack(output int idx, output int lat, output int idle, output bit ok);
    idx = -1; lat = 0; idle = 0; ok = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (req_ack !== 4'b0000) begin
        for (int i = 0; i < 4; i++) if (req_ack[i]) idx = i;
        lat = n; ok = 1'b1;
        break;
      end
      if (busy === 1'b0) idle++;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (busy === 1'b0 && m_busy === 1'b0 && req_ack === 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ack !== 4'b0) begin failures++; $display("FAIL reset_ack got=%b required=0000", req_ack); end
    checks++; if (uart_tx_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b required=0", uart_tx_start); end
    checks++; if (uart_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h required=00", uart_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_gid got=%0d required=0", grant_id); end
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL reset_tmo got=%b required=0", tmo_err); end
    reset = 1'b0;
    mptr = 0;
  endtask

  task automatic test_single_hdr;
    int idx, lat, idle, k, s0, d;
    bit ok;
    frames.delete(); exp_q.delete();
    s0 = start_cnt;
    req_data[7:0] = 8'h55;
    req = 4'b0001;
    wait_ack(idx, lat, idle, ok);
    req = 4'b0000;
    checks++; if (!ok || lat != 1) begin failures++; $display("FAIL single_ack_latency got=%0d required=1", lat); end
    checks++; if (idx != exp_grant(mptr, 4'b0001)) begin failures++; $display("FAIL single_grant got=%0d required=0", idx); end
    mptr = 0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (uart_tx_start === 1'b1) break;
    end
    checks++; if (k != 2) begin failures++; $display("FAIL single_start_latency got=%0d required=2", k); end
    checks++; if (uart_data !== 8'hA0) begin failures++; $display("FAIL single_hdr_byte got=%h required=a0", uart_data); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_idle got=busy required=idle"); end
    exp_q.push_back(8'hA0); exp_q.push_back(8'h55);
    d = q_diff(frames, exp_q);
    checks++; if (d >= 0) begin failures++; $display("FAIL single_frames size=%0d required_size=%0d first_diff=%0d", frames.size(), exp_q.size(), d); end
    checks++; if (start_cnt - s0 != 2) begin failures++; $display("FAIL single_start_count got=%0d required=2", start_cnt - s0); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_gid got=%0d required=0", grant_id); end
  endtask

  task automatic test_round_robin;
    int idx, lat, idle, e, d, bad_order, bad_gap;
    bit ok;
    frames.delete(); exp_q.delete();
    bad_order = 0; bad_gap = 0;
    req_data = $urandom;
    req = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      wait_ack(idx, lat, idle, ok);
      e = exp_grant(mptr, 4'b1111);
      if (!ok || idx != e || grant_id !== 2'(e)) begin
        bad_order++;
        $display("FAIL rr_order grant=%0d got=%0d gid=%0d required=%0d", g, idx, grant_id, e);
      end
      if (g > 0 && idle != 1) begin
        bad_gap++;
        $display("FAIL rr_gap grant=%0d idle_cycles=%0d required=1", g, idle);
      end
      mptr = e;
      exp_q.push_back({4'hA, 4'(e)});
      exp_q.push_back(req_data[8*e +: 8]);
      if (g == 7) req = 4'b0000;
      req_data[8*e +: 8] = 8'($urandom);
    end
    checks++; if (bad_order != 0) failures++;
    checks++; if (bad_gap != 0) failures++;
    wait_idle(ok);
    d = q_diff(frames, exp_q);
    checks++; if (!ok || d >= 0) begin failures++; $display("FAIL rr_frames size=%0d required_size=%0d first_diff=%0d", frames.size(), exp_q.size(), d); end
  endtask

  task automatic test_random;
    int idx, lat, idle, e, d, bad;
    logic [3:0] m;
    bit ok, ok2;
    bad = 0;
    for (int r = 0; r < 12; r++) begin
      frames.delete(); exp_q.delete();
      m = 4'($urandom_range(1, 15));
      req_data = $urandom;
      req = m;
      wait_ack(idx, lat, idle, ok);
      req = 4'b0000;
      e = exp_grant(mptr, m);
      mptr = e;
      exp_q.push_back({4'hA, 4'(e)});
      exp_q.push_back(req_data[8*e +: 8]);
      req_data = $urandom;
      wait_idle(ok2);
      d = q_diff(frames, exp_q);
      if (!ok || !ok2 || idx != e || d >= 0) begin
        bad++;
        $display("FAIL rand_round r=%0d mask=%b got=%0d required=%0d frame_diff=%0d", r, m, idx, e, d);
      end
    end
    checks++; if (bad != 0) failures++;
  endtask

  task automatic test_busy_at_req;
    int idx, lat, idle, k, d, early;
    bit ok;
    frames.delete(); exp_q.delete();
    early = 0;
    req_data[23:16] = 8'($urandom);
    ext_busy = 1'b1;
    req = 4'b0100;
    wait_ack(idx, lat, idle, ok);
    req = 4'b0000;
    checks++; if (!ok || lat != 1 || idx != 2) begin failures++; $display("FAIL busyreq_ack got=%0d lat=%0d required=2 lat=1", idx, lat); end
    mptr = 2;
    repeat (10) begin
      @(negedge clk);
      if (uart_tx_start === 1'b1) early++;
    end
    checks++; if (early != 0) begin failures++; $display("FAIL busyreq_early_start got=%0d required=0", early); end
    ext_busy = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (uart_tx_start === 1'b1) break;
    end
    checks++; if (k < 2 || k > 3) begin failures++; $display("FAIL busyreq_start_delay got=%0d required=2..3", k); end
    wait_idle(ok);
    exp_q.push_back(8'hA2); exp_q.push_back(req_data[23:16]);
    d = q_diff(frames, exp_q);
    checks++; if (!ok || d >= 0) begin failures++; $display("FAIL busyreq_frames size=%0d first_diff=%0d", frames.size(), d); end
  endtask

  task automatic test_timeout;
    int idx, lat, idle, k, d;
    bit ok;
    frames.delete(); exp_q.delete();
    uart_en = 1'b0;
    req_data[15:8] = 8'($urandom);
    req = 4'b0010;
    wait_ack(idx, lat, idle, ok);
    req = 4'b0000;
    checks++; if (!ok || idx != exp_grant(mptr, 4'b0010)) begin failures++; $display("FAIL tmo_grant got=%0d required=1", idx); end
    mptr = 1;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (uart_tx_start === 1'b1) break;
    end
    repeat (250) @(negedge clk);
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b required=0", tmo_err); end
    for (k = 1; k <= 20; k++) begin
      if (tmo_err === 1'b1) break;
      @(negedge clk);
    end
    checks++; if (tmo_err !== 1'b1) begin failures++; $display("FAIL tmo_set got=%b required=1", tmo_err); end
    uart_en = 1'b1;
    wait_idle(ok);
    exp_q.push_back(req_data[15:8]);
    d = q_diff(frames, exp_q);
    checks++; if (!ok || d >= 0) begin failures++; $display("FAIL tmo_next_byte size=%0d required_size=1 first_diff=%0d", frames.size(), d); end
    checks++; if (tmo_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b required=1", tmo_err); end
  endtask

  task automatic test_reset_mid;
    int idx, lat, idle, s0, d;
    bit ok;
    req_data[31:24] = 8'($urandom);
    s0 = start_cnt;
    req = 4'b1000;
    wait_ack(idx, lat, idle, ok);
    req = 4'b0000;
    for (int n = 0; n < 100 && (start_cnt - s0) < 2; n++) @(negedge clk);
    checks++; if (start_cnt - s0 != 2) begin failures++; $display("FAIL rstmid_reach_data got=%0d starts required=2", start_cnt - s0); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (uart_tx_start !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || tmo_err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs start=%b busy=%b gid=%0d tmo=%b required=0 0 0 0", uart_tx_start, busy, grant_id, tmo_err);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 20 && m_busy === 1'b1; n++) @(negedge clk);
    @(negedge clk);
    frames.delete(); exp_q.delete();
    mptr = 0;
    req_data = $urandom;
    req = 4'b1111;
    wait_ack(idx, lat, idle, ok);
    req = 4'b0000;
    checks++; if (!ok || idx != exp_grant(mptr, 4'b1111)) begin failures++; $display("FAIL rstmid_first_grant got=%0d required=1", idx); end
    exp_q.push_back(8'hA1); exp_q.push_back(req_data[15:8]);
    wait_idle(ok);
    d = q_diff(frames, exp_q);
    checks++; if (!ok || d >= 0) begin failures++; $display("FAIL rstmid_frames size=%0d first_diff=%0d", frames.size(), d); end
  endtask

  task automatic test_hdr_off;
    bit acked, done;
    logic [3:0] ackv;
    acked = 1'b0; done = 1'b0; ackv = '0;
    b_frames.delete();
    b_data[23:16] = 8'hC3;
    b_req = 4'b0100;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (b_ack !== 4'b0) begin acked = 1'b1; ackv = b_ack; break; end
    end
    b_req = 4'b0000;
    checks++; if (!acked || ackv !== 4'b0100) begin failures++; $display("FAIL nohdr_ack got=%b required=0100", ackv); end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (b_busy === 1'b0 && b_ubusy === 1'b0) begin done = 1'b1; break; end
    end
    checks++; if (!done || b_frames.size() != 1) begin failures++; $display("FAIL nohdr_frame_count got=%0d required=1", b_frames.size()); end
    checks++; if (b_frames.size() < 1 || b_frames[0] !== 8'hC3) begin failures++; $display("FAIL nohdr_byte got=%h required=c3", (b_frames.size() > 0) ? b_frames[0] : 8'hxx); end
    checks++; if (b_gid !== 2'd2) begin failures++; $display("FAIL nohdr_gid got=%0d required=2", b_gid); end
  endtask

  initial begin
    test_reset();
    test_single_hdr();
    test_round_robin();
    test_random();
    test_busy_at_req();
    test_timeout();
    test_reset_mid();
    test_hdr_off();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
